// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the consumer and alu_arbiter.
// rsp_err exists only when ALU_ARB_OPCHECK_EN is defined.
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
`ifdef ALU_ARB_OPCHECK_EN
  logic             rsp_err;
`endif

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
`ifdef ALU_ARB_OPCHECK_EN
    , output rsp_err
`endif
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
`ifdef ALU_ARB_OPCHECK_EN
    , input rsp_err
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU, one registered response.
// Zero-bubble response handoff; ALU_ARB_OPCHECK_EN adds illegal-opcode detection and rsp_err.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       ctl_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] alu_out_o,
  output logic             zero_o
);
  always_comb begin
    alu_out_o = '0;
    case (ctl_i)
      4'b0000: alu_out_o = x_i & y_i;
      4'b0001: alu_out_o = x_i | y_i;
      4'b0010: alu_out_o = x_i + y_i;
      4'b0110: alu_out_o = x_i - y_i;
      default: alu_out_o = '0;
    endcase
    zero_o = (alu_out_o == '0);
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH       = 64,
  parameter int FIRST_GRANT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  // Pointer resets to the opposite of FIRST_GRANT so the first contended cycle goes to FIRST_GRANT.
  localparam logic LAST_INIT = (FIRST_GRANT == 0);

  logic             last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic             xfer;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic [WIDTH-1:0] load_result;
  logic             load_zero;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign grant_vld  = bus.req0_valid || bus.req1_valid;
  assign grant_id   = (bus.req0_valid && bus.req1_valid) ? !last_q : bus.req1_valid;
  assign xfer       = can_accept && grant_vld;

  assign bus.req0_ready = xfer && !grant_id;
  assign bus.req1_ready = xfer && grant_id;

  assign sel_op = grant_id ? bus.req1_op : bus.req0_op;
  assign sel_x  = grant_id ? bus.req1_x  : bus.req0_x;
  assign sel_y  = grant_id ? bus.req1_y  : bus.req0_y;

  alu #(.WIDTH(WIDTH)) u_alu (
    .ctl_i     (sel_op),
    .x_i       (sel_x),
    .y_i       (sel_y),
    .alu_out_o (alu_out),
    .zero_o    (alu_zero)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic op_legal;
  logic rsp_err_q, rsp_err_d;

  assign op_legal    = (sel_op == 4'b0000) || (sel_op == 4'b0001) ||
                       (sel_op == 4'b0010) || (sel_op == 4'b0110);
  assign load_result = op_legal ? alu_out : '0;
  assign load_zero   = op_legal && alu_zero;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (xfer) rsp_err_d = !op_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign load_result = alu_out;
  assign load_zero   = alu_zero;
`endif

  // Data fields hold after a retire; only rsp_valid drops.
  always_comb begin
    last_d       = last_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    if (xfer) begin
      last_d       = grant_id;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_result_d = load_result;
      rsp_zero_d   = load_zero;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= LAST_INIT;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      last_q       <= last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table, random traffic against a reference model, reset corner cases.
module tb_alu_arbiter;
  localparam int WIDTH       = 64;
  localparam int FIRST_GRANT = 0;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .FIRST_GRANT(FIRST_GRANT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v0;
    logic [3:0]  op0;
    logic [63:0] x0, y0;
    logic        v1;
    logic [3:0]  op1;
    logic [63:0] x1, y1;
    logic        rr;
    logic        e_r0, e_r1, e_rv, e_id;
    logic [63:0] e_res;
    logic        e_zero, e_err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: the visible response plus who won most recently.
  logic        m_rv, m_id, m_zero, m_err;
  logic [63:0] m_res;
  int          m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      default: return 64'd0;
    endcase
  endfunction

  function automatic vec_t row(input logic v0, input logic [3:0] op0, input logic [63:0] x0, input logic [63:0] y0,
                               input logic v1, input logic [3:0] op1, input logic [63:0] x1, input logic [63:0] y1,
                               input logic rr, input logic er0, input logic er1, input logic erv, input logic eid,
                               input logic [63:0] eres, input logic ezero);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.x0 = x0; v.y0 = y0;
    v.v1 = v1; v.op1 = op1; v.x1 = x1; v.y1 = y1;
    v.rr = rr; v.e_r0 = er0; v.e_r1 = er1; v.e_rv = erv; v.e_id = eid;
    v.e_res = eres; v.e_zero = ezero; v.e_err = 1'b0;
    return v;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t  o = v;
    bit    can = !m_rv || v.rr;
    int    winner = -1;
    logic [3:0]  op;
    logic [63:0] x, y;
    if (v.v0 && v.v1) winner = (m_last == 0) ? 1 : 0;
    else if (v.v0)    winner = 0;
    else if (v.v1)    winner = 1;
    o.e_r0 = can && winner == 0;
    o.e_r1 = can && winner == 1;
    if (can && winner >= 0) begin
      op = (winner == 1) ? v.op1 : v.op0;
      x  = (winner == 1) ? v.x1  : v.x0;
      y  = (winner == 1) ? v.y1  : v.y0;
      o.e_rv = 1'b1;
      o.e_id = (winner == 1);
`ifdef ALU_ARB_OPCHECK_EN
      o.e_err  = !is_legal(op);
      o.e_res  = is_legal(op) ? ref_alu(op, x, y) : 64'd0;
      o.e_zero = is_legal(op) && (o.e_res == 64'd0);
`else
      o.e_err  = 1'b0;
      o.e_res  = ref_alu(op, x, y);
      o.e_zero = (o.e_res == 64'd0);
`endif
    end else begin
      o.e_rv   = v.rr ? 1'b0 : m_rv;
      o.e_id   = m_id;
      o.e_res  = m_res;
      o.e_zero = m_zero;
      o.e_err  = m_err;
    end
    return o;
  endfunction

  task automatic drive(input vec_t v);
    bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_x = v.x0; bus.req0_y = v.y0;
    bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_x = v.x1; bus.req1_y = v.y1;
    bus.rsp_ready  = v.rr;
  endtask

  // Called at posedge+1: inputs, readys mid-cycle, registered response just after the next edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #3;
    chk({tag, " req0_ready"}, 64'(bus.req0_ready), 64'(v.e_r0));
    chk({tag, " req1_ready"}, 64'(bus.req1_ready), 64'(v.e_r1));
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(v.e_rv));
    chk({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(v.e_id));
    chk({tag, " rsp_result"}, bus.rsp_result, v.e_res);
    chk({tag, " rsp_zero"}, 64'(bus.rsp_zero), 64'(v.e_zero));
`ifdef ALU_ARB_OPCHECK_EN
    chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(v.e_err));
`endif
    if (v.e_r0 && v.v0)      m_last = 0;
    else if (v.e_r1 && v.v1) m_last = 1;
    m_rv = v.e_rv; m_id = v.e_id; m_res = v.e_res; m_zero = v.e_zero; m_err = v.e_err;
  endtask

  task automatic model_reset();
    m_rv = 1'b0; m_id = 1'b0; m_res = 64'd0; m_zero = 1'b0; m_err = 1'b0;
    m_last = (FIRST_GRANT == 0) ? 1 : 0;
  endtask

  task automatic do_reset(input string tag);
    drive(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " rst rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, " rst rsp_result"}, bus.rsp_result, 64'd0);
    chk({tag, " rst rsp_zero"}, 64'(bus.rsp_zero), 64'd0);
    chk({tag, " rst rsp_id"}, 64'(bus.rsp_id), 64'd0);
`ifdef ALU_ARB_OPCHECK_EN
    chk({tag, " rst rsp_err"}, 64'(bus.rsp_err), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [63:0] andv;
    andv = 64'hAAAA & 64'h0110;
    model_reset();

    // Single requester ADD.
    do_reset("t1");
    apply(row(1, OP_ADD, 123, 321, 0, 0, 0, 0, 1, 1, 0, 1, 0, 444, 0), "t1 add");

    do_reset("t2");
    // Contention alternates starting with FIRST_GRANT (0); pointer survives idle gaps.
    tbl.push_back(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 1, 0, 1, 0, 64, 0));
    tbl.push_back(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 0, 1, 1, 1, andv, andv == 0));
    tbl.push_back(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 1, 0, 1, 0, 64, 0));
    tbl.push_back(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 0, 1, 1, 1, andv, andv == 0));
    tbl.push_back(row(0, 0, 0, 0, 1, OP_SUB, 12345, 12345, 1, 0, 1, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(1, OP_OR, 64'h0000AAAA, 64'hAAAA0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(row(1, OP_OR, 64'h0000AAAA, 64'hAAAA0000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 64'hAAAAAAAA, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 64'hAAAAAAAA, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hAAAAAAAA, 0));
    tbl.push_back(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 0, 1, 1, 1, andv, andv == 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, andv, andv == 0));
    tbl.push_back(row(1, OP_ADD, 64'hFFFFFFFFFFFFFFFF, 2, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, OP_SUB, 0, 1, 1, 0, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Random traffic, legal opcodes only.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ops[4];
      ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
      v = row($urandom_range(0, 1), ops[$urandom_range(0, 3)], {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 1), ops[$urandom_range(0, 3)], {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 9) < 7), 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 7) == 0) v.y0 = v.x0;
      if ($urandom_range(0, 7) == 0) v.y1 = v.x1;
      apply(predict(v), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges while a response is pending.
    apply(predict(row(1, OP_ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)), "t5 load");
    drive(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 async rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5 async rsp_result", bus.rsp_result, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    apply(row(1, OP_SUB, 128, 64, 1, OP_AND, 64'hAAAA, 64'h0110, 1, 1, 0, 1, 0, 64, 0), "t5 first grant");

`ifdef ALU_ARB_OPCHECK_EN
    do_reset("t6");
    v = row(1, 4'b1111, 5, 7, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    v.e_err = 1'b1;
    apply(v, "t6 illegal");
    apply(row(1, OP_ADD, 750, 250, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1000, 0), "t6 legal");
    for (int i = 0; i < 40; i++) begin
      v = row($urandom_range(0, 1), 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 1), 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 1), 0, 0, 0, 0, 0, 0);
      apply(predict(v), $sformatf("t6 rnd%0d", i));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
